// File: rtl/skip_cnt_pkg.sv
// Shared types and the successor function of the skip-value counter.
// Used by the checker RTL and by benches that model the counter sequence.
package skip_cnt_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Next value of an n-bit counter that never takes the value 'skip'.
    function automatic int skip_next(input int x, input int n, input int skip);
        int m;
        int y;
        m = 1 << n;
        y = (x + 1) % m;
        if (y == skip) begin
            y = (y + 1) % m;
        end
        return y;
    endfunction

endpackage

// File: rtl/skip_count_checker_if.sv
// Observation bus between a skip-value counter (master) and its checker (slave).
// valid-only handshake: cnt_in is sampled on a rising clk edge whenever valid_in
// is high; there is no back-pressure, the checker accepts every valid sample.
interface skip_count_checker_if #(
    parameter int N     = 5,
    parameter int ERR_W = 8
);
    logic [N-1:0]     cnt_in;
    logic             valid_in;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [N-1:0]     expected;
    logic [1:0]       dbg_state;

    modport master (
        output cnt_in, valid_in,
        input  locked, err_pulse, err_count, expected, dbg_state
    );

    modport slave (
        input  cnt_in, valid_in,
        output locked, err_pulse, err_count, expected, dbg_state
    );
endinterface

// File: rtl/skip_count_checker.sv
// Sequence checker for a skip-value counter: acquires lock on the sequence,
// then strobes and counts (saturating) every deviation.
module skip_count_checker
    import skip_cnt_pkg::*;
#(
    parameter int N     = 5,
    parameter int SKIP  = 3,
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    skip_count_checker_if.slave bus
);

    state_t           r_state;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;
    logic [N-1:0]     r_expected;

    logic [N-1:0] w_nxt;
    logic         w_illegal;
    logic         w_match;
    logic         w_err;

    assign w_nxt     = N'(skip_next(int'(bus.cnt_in), N, SKIP));
    assign w_illegal = (int'(bus.cnt_in) == SKIP);
    assign w_match   = (bus.cnt_in == r_expected);

    // Only a locked tracker treats a legal mismatch as an error.
    always_comb begin
        w_err = 1'b0;
        if (bus.valid_in) begin
            case (r_state)
                HUNT, CONFIRM: w_err = w_illegal;
                LOCKED:        w_err = !w_match;
                default:       w_err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_expected  <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err && (r_err_count != {ERR_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (bus.valid_in) begin
                case (r_state)
                    HUNT: begin
                        if (!w_illegal) begin
                            r_expected <= w_nxt;
                            r_state    <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (w_illegal) begin
                            r_state <= HUNT;
                        end else begin
                            r_expected <= w_nxt;
                            if (w_match) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_expected <= w_nxt;
                        end else begin
                            r_state  <= HUNT;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
    assign bus.expected  = r_expected;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_skip_count_checker.sv
// Bench for skip_count_checker: directed scenarios then random traffic, checked
// against a sequence-level model; a second instance has a 2-bit error counter.
module tb_skip_count_checker;
    import skip_cnt_pkg::*;

    localparam int N    = 5;
    localparam int SKIP = 3;

    logic clk;
    logic rst;

    skip_count_checker_if #(.N(N), .ERR_W(8)) bus ();
    skip_count_checker_if #(.N(N), .ERR_W(2)) bus2 ();

    skip_count_checker #(.N(N), .SKIP(SKIP), .ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    skip_count_checker #(.N(N), .SKIP(SKIP), .ERR_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: tracking phase 0 = searching, 1 = one sample seen, 2 = tracking.
    int m_phase;
    int m_exp;
    int m_cnt8;
    int m_cnt2;
    bit m_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit v, input int s, input bit r);
        bit err;
        err = 0;
        if (r) begin
            m_phase = 0; m_exp = 0; m_cnt8 = 0; m_cnt2 = 0; m_pulse = 0;
            return;
        end
        if (v) begin
            if (m_phase == 2) begin
                if (s == m_exp) m_exp = skip_next(s, N, SKIP);
                else begin err = 1; m_phase = 0; end
            end else if (s == SKIP) begin
                err = 1;
                m_phase = 0;
            end else begin
                if (m_phase == 1 && s == m_exp) m_phase = 2;
                else m_phase = 1;
                m_exp = skip_next(s, N, SKIP);
            end
        end
        m_pulse = err;
        if (err) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic step(input string tag, input bit v, input int s, input bit r);
        @(negedge clk);
        rst = r;
        bus.valid_in  = v;
        bus.cnt_in    = N'(s);
        bus2.valid_in = v;
        bus2.cnt_in   = N'(s);
        @(posedge clk);
        #1;
        model(v, s, r);
        chk({tag, "_locked"},   32'(bus.locked),     32'(m_phase == 2));
        chk({tag, "_pulse"},    32'(bus.err_pulse),  32'(m_pulse));
        chk({tag, "_count"},    32'(bus.err_count),  32'(m_cnt8));
        chk({tag, "_expected"}, 32'(bus.expected),   32'(m_exp));
        chk({tag, "_pulse2"},   32'(bus2.err_pulse), 32'(m_pulse));
        chk({tag, "_count2"},   32'(bus2.err_count), 32'(m_cnt2));
        chk({tag, "_locked2"},  32'(bus2.locked),    32'(m_phase == 2));
    endtask

    initial begin
        int g;
        int s;
        bit v;
        rst = 1'b1;
        bus.valid_in = 1'b0;  bus.cnt_in = '0;
        bus2.valid_in = 1'b0; bus2.cnt_in = '0;

        // Reset state
        step("rst", 0, 0, 1);
        step("rst", 1, 7, 1);
        chk("rst_state", 32'(bus.dbg_state), 32'd0);

        // 1: acquire lock across the skipped value
        step("t1", 1, 0, 0);
        step("t1", 1, 1, 0);
        chk("t1_locked_after_1", 32'(bus.locked), 32'd1);
        step("t1", 1, 2, 0);
        step("t1", 1, 4, 0);
        step("t1", 1, 5, 0);
        chk("t1_exp6", 32'(bus.expected), 32'd6);

        // 2: wrap 31 -> 0 while locked
        for (int k = 6; k <= 29; k++) step("t2_run", 1, k, 0);
        step("t2", 1, 30, 0);
        step("t2", 1, 31, 0);
        chk("t2_exp_after_31", 32'(bus.expected), 32'd0);
        step("t2", 1, 0, 0);
        step("t2", 1, 1, 0);
        chk("t2_no_err", 32'(bus.err_count), 32'd0);

        // 3: mismatch while locked, then relock
        for (int k = 2; k <= 9; k++) if (k != SKIP) step("t3_run", 1, k, 0);
        chk("t3_exp10", 32'(bus.expected), 32'd10);
        step("t3", 1, 12, 0);
        chk("t3_pulse", 32'(bus.err_pulse), 32'd1);
        chk("t3_count", 32'(bus.err_count), 32'd1);
        chk("t3_exp_held", 32'(bus.expected), 32'd10);
        step("t3", 1, 13, 0);
        chk("t3_pulse_drop", 32'(bus.err_pulse), 32'd0);
        step("t3", 1, 14, 0);
        chk("t3_relock", 32'(bus.locked), 32'd1);

        // 4: illegal value in each phase
        step("t4_rst", 1, 0, 1);
        step("t4_hunt", 1, SKIP, 0);
        chk("t4_hunt_state", 32'(bus.dbg_state), 32'd0);
        step("t4", 1, 7, 0);
        step("t4_conf", 1, SKIP, 0);
        chk("t4_conf_state", 32'(bus.dbg_state), 32'd0);
        step("t4", 1, 7, 0);
        step("t4", 1, 8, 0);
        step("t4_lock", 1, SKIP, 0);
        chk("t4_lock_state", 32'(bus.dbg_state), 32'd0);
        chk("t4_count3", 32'(bus.err_count), 32'd3);

        // 5: gaps in valid_in, then reset mid-stream
        step("t5", 1, 20, 0);
        step("t5", 1, 21, 0);
        for (int k = 0; k < 4; k++) step("t5_gap", 0, $urandom_range(0, 31), 0);
        step("t5", 1, 22, 0);
        chk("t5_still_locked", 32'(bus.locked), 32'd1);
        step("t5_rst", 1, 23, 1);
        chk("t5_rst_exp", 32'(bus.expected), 32'd0);

        // 6: saturation of the narrow counter
        for (int k = 0; k < 5; k++) step("t6", 1, SKIP, 0);
        chk("t6_sat2", 32'(bus2.err_count), 32'd3);
        chk("t6_cnt8", 32'(bus.err_count), 32'd5);

        // Random traffic around a legal stream
        g = 0;
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(0, 9) < 8);
            if (v) g = skip_next(g, N, SKIP);
            case ($urandom_range(0, 19))
                0, 1:    s = $urandom_range(0, 31);
                2:       s = SKIP;
                default: s = g;
            endcase
            step("rand", v, s, ($urandom_range(0, 99) < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
